// File: rtl/multi_flash_pkg.sv
// rtl/multi_flash_pkg.sv - shared types for the multi-channel LED flasher
//
// Purpose: the channel state encoding and the reset value of the per-channel
//          control record. The burst counter width is a parameter of each
//          channel, so the counter is kept outside this record.
// Ports:   none (package)
package multi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLASH   = 2'd2
    } flash_state_t;

    typedef struct packed {
        flash_state_t state;
        logic         led;
        logic         busy;
        logic         hold_q;
    } chan_ctl_t;

    localparam chan_ctl_t CHAN_RST = '{state: IDLE, led: 1'b0, busy: 1'b0, hold_q: 1'b0};

endpackage

// File: rtl/flash_channel.sv
// rtl/flash_channel.sv - one LED flasher channel: FSM, burst counter, LED register
//
// Purpose: waits for the shared tick after a trigger, then flashes the LED for
//          FLASH_COUNT tick periods, or indefinitely if hold was set when the
//          burst started. cancel aborts at any time.
// Ports:   clk, reset_n (async, active-low), tick (shared strobe),
//          trigger / cancel (one-cycle pulses), hold (mode, sampled at burst
//          start), LED and busy (registered outputs).
module flash_channel
    import multi_flash_pkg::*;
#(
    parameter int FLASH_COUNT = 6,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic trigger,
    input  logic cancel,
    input  logic hold,
    output logic LED,
    output logic busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLASH_COUNT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    chan_ctl_t        ctl_q, ctl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_q <= CHAN_RST;
            cnt_q <= '0;
        end else begin
            ctl_q <= ctl_d;
            cnt_q <= cnt_d;
        end
    end

    // A burst begins on the first tick seen while pending, or immediately
    // when the trigger itself coincides with a tick.
    always_comb begin
        ctl_d = ctl_q;
        cnt_d = cnt_q;
        start = 1'b0;

        if (cancel) begin
            ctl_d = CHAN_RST;
            cnt_d = '0;
        end else begin
            case (ctl_q.state)
                IDLE: begin
                    if (trigger) begin
                        if (tick) start = 1'b1;
                        else      ctl_d.state = PENDING;
                    end
                end
                PENDING: begin
                    if (tick) start = 1'b1;
                end
                FLASH: begin
                    if (trigger) begin
                        // Retrigger extends the burst; level and hold mode stay put.
                        cnt_d = RELOAD;
                        if (tick) ctl_d.led = ~ctl_q.led;
                    end else if (tick) begin
                        if (ctl_q.hold_q) begin
                            ctl_d.led = ~ctl_q.led;
                        end else if (cnt_q > ONE) begin
                            cnt_d     = cnt_q - ONE;
                            ctl_d.led = ~ctl_q.led;
                        end else begin
                            cnt_d       = '0;
                            ctl_d.led   = 1'b0;
                            ctl_d.state = IDLE;
                        end
                    end
                end
                default: begin
                    ctl_d = CHAN_RST;
                    cnt_d = '0;
                end
            endcase

            if (start) begin
                ctl_d.state  = FLASH;
                ctl_d.led    = 1'b1;
                ctl_d.hold_q = hold;
                cnt_d        = RELOAD;
            end
        end

        ctl_d.busy = (ctl_d.state != IDLE);
    end

    assign LED  = ctl_q.led;
    assign busy = ctl_q.busy;

endmodule

// File: rtl/multi_flash_light.sv
// rtl/multi_flash_light.sv - multi-channel LED flasher with shared prescaler
//
// Purpose: divides clk_40MHz down to a one-cycle flash tick and drives
//          CHANNELS independent flash_channel instances from it.
// Ports:   clk_40MHz, reset_n (async, active-low),
//          trigger / cancel / hold [CHANNELS] per-channel controls,
//          LED / busy [CHANNELS] per-channel outputs, tick shared strobe.
module multi_flash_light #(
    parameter int CHANNELS    = 4,
    parameter int CLK_DIV     = 20000000,
    parameter int FLASH_COUNT = 6,
    parameter int CNT_W       = 4,
    parameter int DIV_W       = 25
) (
    input  logic                clk_40MHz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [CHANNELS-1:0] cancel,
    input  logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] LED,
    output logic [CHANNELS-1:0] busy,
    output logic                tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    // tick is registered from the terminal count, so it rises the cycle
    // after the prescaler reads CLK_DIV-1.
    always_ff @(posedge clk_40MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (div_q == DIV_LAST);
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        flash_channel #(
            .FLASH_COUNT (FLASH_COUNT),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk     (clk_40MHz),
            .reset_n (reset_n),
            .tick    (tick),
            .trigger (trigger[g]),
            .cancel  (cancel[g]),
            .hold    (hold[g]),
            .LED     (LED[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_flash_light.sv
// tb/tb_multi_flash_light.sv - self-checking bench for multi_flash_light
`timescale 1ns/1ps
module tb_multi_flash_light;

    logic       clk_40MHz = 1'b0;
    logic       reset_n;
    logic [3:0] trigger, cancel, hold;
    logic [3:0] LED, busy;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk_40MHz = ~clk_40MHz;

    multi_flash_light #(
        .CHANNELS    (4),
        .CLK_DIV     (4),
        .FLASH_COUNT (6),
        .CNT_W       (4),
        .DIV_W       (3)
    ) dut (
        .clk_40MHz (clk_40MHz),
        .reset_n   (reset_n),
        .trigger   (trigger),
        .cancel    (cancel),
        .hold      (hold),
        .LED       (LED),
        .busy      (busy),
        .tick      (tick)
    );

    typedef struct {
        int         adv;
        logic [3:0] trig;
        logic [3:0] canc;
        logic [3:0] hld;
        logic [3:0] led;
        logic [3:0] bsy;
    } row_t;

    row_t rows[$];

    task automatic add(input int a, input logic [3:0] t, input logic [3:0] c,
                       input logic [3:0] h, input logic [3:0] l, input logic [3:0] b);
        row_t r;
        r.adv = a; r.trig = t; r.canc = c; r.hld = h; r.led = l; r.bsy = b;
        rows.push_back(r);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_40MHz);
        #1;
        edge_n++;
    endtask

    initial begin
        reset_n = 1'b0;
        trigger = '0;
        cancel  = '0;
        hold    = '0;

        // adv = clock edges consumed by the row (first edge carries the pulses),
        // expectations are checked after the last of them.
        // Basic burst on channel 0, trigger mid-period.
        add(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e1
        add(1,  4'h1, 4'h0, 4'h0, 4'h0, 4'h1); // e2 pending
        add(2,  4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e4
        add(1,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e5 first tick -> LED on
        add(3,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e8
        add(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e9
        add(4,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e13
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e17
        add(4,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e21
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e25
        add(3,  4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e28
        add(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e29 7th tick -> idle
        // Trigger coincident with tick on channel 1.
        add(3,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e32
        add(1,  4'h2, 4'h0, 4'h0, 4'h2, 4'h2); // e33 straight to FLASH
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'h2); // e37
        add(12, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2); // e49
        add(7,  4'h0, 4'h0, 4'h0, 4'h0, 4'h2); // e56
        add(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e57 six periods done
        // Retrigger channel 0 in its 4th period.
        add(1,  4'h1, 4'h0, 4'h0, 4'h0, 4'h1); // e58
        add(3,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e61
        add(12, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1); // e73
        add(1,  4'h1, 4'h0, 4'h0, 4'h0, 4'h1); // e74 retrigger, no glitch
        add(3,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e77
        add(8,  4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e85 still running
        add(11, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1); // e96
        add(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e97 6th tick after retrigger
        // Hold mode on channel 2, hold released after latching.
        add(1,  4'h4, 4'h0, 4'h4, 4'h0, 4'h4); // e98
        add(3,  4'h0, 4'h0, 4'h4, 4'h4, 4'h4); // e101
        add(88, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4); // e189 after 22 toggles
        add(2,  4'h0, 4'h0, 4'h0, 4'h4, 4'h4); // e191
        add(1,  4'h0, 4'h4, 4'h0, 4'h0, 4'h0); // e192 cancel
        add(1,  4'h4, 4'h4, 4'h0, 4'h0, 4'h0); // e193 cancel+trigger on a tick
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0); // e197
        // All channels together, then cancel channel 1 on a tick edge.
        add(1,  4'hF, 4'h0, 4'h0, 4'h0, 4'hF); // e198
        add(3,  4'h0, 4'h0, 4'h0, 4'hF, 4'hF); // e201
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'hF); // e205
        add(3,  4'h0, 4'h0, 4'h0, 4'h0, 4'hF); // e208
        add(1,  4'h0, 4'h2, 4'h0, 4'hD, 4'hD); // e209
        add(4,  4'h0, 4'h0, 4'h0, 4'h0, 4'hD); // e213

        repeat (3) @(posedge clk_40MHz);
        #1;
        check("reset_led",  0, 32'(LED),  32'h0);
        check("reset_busy", 0, 32'(busy), 32'h0);
        check("reset_tick", 0, 32'(tick), 32'h0);

        reset_n = 1'b1;
        edge_n  = 0;

        foreach (rows[i]) begin
            trigger = rows[i].trig;
            cancel  = rows[i].canc;
            hold    = rows[i].hld;
            step();
            trigger = '0;
            cancel  = '0;
            for (int k = 1; k < rows[i].adv; k++) step();
            check("led",  i, 32'(LED),  32'(rows[i].led));
            check("busy", i, 32'(busy), 32'(rows[i].bsy));
            check("tick", i, 32'(tick), 32'((edge_n % 4) == 0));
        end

        // Asynchronous reset while channels 0, 2 and 3 are flashing and tick is high.
        repeat (3) step();
        check("pre_reset_tick", edge_n, 32'(tick), 32'h1);
        check("pre_reset_busy", edge_n, 32'(busy), 32'hD);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_led",  0, 32'(LED),  32'h0);
        check("async_busy", 0, 32'(busy), 32'h0);
        check("async_tick", 0, 32'(tick), 32'h0);

        @(negedge clk_40MHz);
        reset_n = 1'b1;
        edge_n  = 0;
        for (int n = 1; n <= 9; n++) begin
            step();
            check("post_reset_tick", n, 32'(tick), 32'((n % 4) == 0));
        end
        check("post_reset_led",  0, 32'(LED),  32'h0);
        check("post_reset_busy", 0, 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
